// File: rtl/psum_drain_pkg.sv
// Shared widths and drain FSM state encodings for the psum drain path.
package psum_drain_pkg;

    localparam int WORD_WIDTH       = 128;
    localparam int GBUFF_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        DRN_IDLE  = 2'd0,
        DRN_RUN   = 2'd1,
        DRN_FLUSH = 2'd2,
        DRN_DONE  = 2'd3
    } drn_state_e;

endpackage

// File: rtl/psum_drain_sync_fifo.sv
// Small synchronous FIFO holding psum words between the PE array and the output buffer.
module sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/psum_drain.sv
// Drains psum words from the PE array into the output global buffer at consecutive addresses.
module psum_drain #(
    parameter int WORD_WIDTH = psum_drain_pkg::WORD_WIDTH,
    parameter int ADDR_WIDTH = psum_drain_pkg::GBUFF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  num_words_i,
    input  logic [WORD_WIDTH-1:0] wordp_i,
    input  logic                  wordp_valid_i,
    output logic                  gbuff_wr_en_o,
    output logic [ADDR_WIDTH-1:0] gbuff_addr_o,
    output logic [WORD_WIDTH-1:0] gbuff_wdata_o,
    input  logic                  gbuff_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o
);
    import psum_drain_pkg::*;

    drn_state_e            state;
    drn_state_e            state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [CNT_WIDTH-1:0]  acc_q;
    logic                  overflow_q;

    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [WORD_WIDTH-1:0] head;

    // A word offered while full is still counted, so a job always terminates.
    assign push_req = wordp_valid_i && (state == DRN_RUN) && (acc_q < num_q);
    assign pop      = !empty && gbuff_ready_i;
    assign push     = push_req && (!full || pop);

    sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .pop   (pop),
        .wdata (wordp_i),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            DRN_IDLE: begin
                if (start_i) state_nxt = (num_words_i == '0) ? DRN_DONE : DRN_RUN;
            end
            DRN_RUN: begin
                if (acc_q == num_q) state_nxt = DRN_FLUSH;
            end
            DRN_FLUSH: begin
                if (empty) state_nxt = DRN_DONE;
            end
            DRN_DONE: state_nxt = DRN_IDLE;
            default:  state_nxt = DRN_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= DRN_IDLE;
            addr_q     <= '0;
            num_q      <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == DRN_IDLE) && start_i) begin
                addr_q     <= base_addr_i;
                num_q      <= num_words_i;
                acc_q      <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (pop)                      addr_q     <= addr_q + 1'b1;
                if (push_req)                 acc_q      <= acc_q + 1'b1;
                if (push_req && full && !pop) overflow_q <= 1'b1;
            end
        end
    end

    // Data is masked while empty so the write port reads all-zero out of reset.
    assign gbuff_wr_en_o = !empty;
    assign gbuff_addr_o  = addr_q;
    assign gbuff_wdata_o = empty ? '0 : head;
    assign busy_o        = (state != DRN_IDLE);
    assign done_o        = (state == DRN_DONE);
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain with a write scoreboard checked at the buffer port.
module tb_psum_drain;
    localparam int WW = 128;
    localparam int AW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [CW-1:0] num_words_i;
    logic [WW-1:0] wordp_i;
    logic          wordp_valid_i;
    logic          gbuff_wr_en_o;
    logic [AW-1:0] gbuff_addr_o;
    logic [WW-1:0] gbuff_wdata_o;
    logic          gbuff_ready_i;
    logic          busy_o;
    logic          done_o;
    logic          overflow_o;

    always #5 clk = ~clk;

    psum_drain #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .num_words_i   (num_words_i),
        .wordp_i       (wordp_i),
        .wordp_valid_i (wordp_valid_i),
        .gbuff_wr_en_o (gbuff_wr_en_o),
        .gbuff_addr_o  (gbuff_addr_o),
        .gbuff_wdata_o (gbuff_wdata_o),
        .gbuff_ready_i (gbuff_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .overflow_o    (overflow_o)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    int            errors = 0;
    int            checks = 0;
    int            writes = 0;
    int            done_pulses = 0;
    bit            toggle_ready = 1'b0;
    bit            held = 1'b0;
    logic [AW-1:0] held_addr;
    logic [WW-1:0] held_data;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: sampled on the falling edge, between driving edges.
    always @(negedge clk) begin
        if (held) begin
            chk("hold_wr_en", WW'(gbuff_wr_en_o), WW'(1'b1));
            chk("hold_addr", WW'(gbuff_addr_o), WW'(held_addr));
            chk("hold_data", gbuff_wdata_o, held_data);
        end
        if (rst_ni && gbuff_wr_en_o && gbuff_ready_i) begin
            writes++;
            chk("write_expected", WW'(exp_q.size() != 0), WW'(1'b1));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("write_addr", WW'(gbuff_addr_o), WW'(mon_e.addr));
                chk("write_data", gbuff_wdata_o, mon_e.data);
            end
        end
        held      = rst_ni && gbuff_wr_en_o && !gbuff_ready_i;
        held_addr = gbuff_addr_o;
        held_data = gbuff_wdata_o;
        if (done_o) done_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_ready) gbuff_ready_i = ~gbuff_ready_i;
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [CW-1:0] num);
        base_addr_i = base;
        num_words_i = num;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic drive_word(input logic [WW-1:0] d, input bit expect_it, input logic [AW-1:0] a);
        wordp_i       = d;
        wordp_valid_i = 1'b1;
        if (expect_it) exp_q.push_back('{addr: a, data: d});
        tick();
        wordp_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (!done_o && n < max) begin
            tick();
            n++;
        end
        chk(tag, WW'(done_o), WW'(1'b1));
    endtask

    function automatic logic [WW-1:0] pat(input int job, input int idx);
        return {4{8'(job), 8'(idx), 16'hC0DE ^ 16'(idx * 37)}};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pb;
        int wb;
        rst_ni        = 1'b0;
        start_i       = 1'b0;
        base_addr_i   = '0;
        num_words_i   = '0;
        wordp_i       = '0;
        wordp_valid_i = 1'b0;
        gbuff_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_wr_en", WW'(gbuff_wr_en_o), WW'(1'b0));
        chk("rst_addr", WW'(gbuff_addr_o), WW'(8'h00));
        chk("rst_wdata", gbuff_wdata_o, '0);
        chk("rst_busy", WW'(busy_o), WW'(1'b0));
        chk("rst_done", WW'(done_o), WW'(1'b0));
        chk("rst_overflow", WW'(overflow_o), WW'(1'b0));
        rst_ni = 1'b1;
        tick();

        // Job 1: three words back-to-back from base 0x10.
        gbuff_ready_i = 1'b1;
        pb = done_pulses;
        wb = writes;
        start_job(8'h10, 8'd3);
        chk("j1_busy", WW'(busy_o), WW'(1'b1));
        drive_word(pat(1, 0), 1'b1, 8'h10);
        chk("j1_lat_wr_en", WW'(gbuff_wr_en_o), WW'(1'b1));
        chk("j1_lat_addr", WW'(gbuff_addr_o), WW'(8'h10));
        chk("j1_lat_data", gbuff_wdata_o, pat(1, 0));
        drive_word(pat(1, 1), 1'b1, 8'h11);
        drive_word(pat(1, 2), 1'b1, 8'h12);
        wait_done("j1_done", 20);
        tick();
        tick();
        chk("j1_done_clear", WW'(done_o), WW'(1'b0));
        chk("j1_done_pulses", WW'(done_pulses - pb), WW'(1));
        chk("j1_writes", WW'(writes - wb), WW'(3));
        chk("j1_overflow", WW'(overflow_o), WW'(1'b0));
        chk("j1_sb_empty", WW'(exp_q.size()), WW'(0));

        // Job 2: address wrap from 0xFE.
        pb = done_pulses;
        wb = writes;
        start_job(8'hFE, 8'd3);
        drive_word(pat(2, 0), 1'b1, 8'hFE);
        drive_word(pat(2, 1), 1'b1, 8'hFF);
        drive_word(pat(2, 2), 1'b1, 8'h00);
        wait_done("j2_done", 20);
        tick();
        chk("j2_done_pulses", WW'(done_pulses - pb), WW'(1));
        chk("j2_writes", WW'(writes - wb), WW'(3));
        chk("j2_sb_empty", WW'(exp_q.size()), WW'(0));

        // Job 3: buffer stalled, fifth word dropped.
        gbuff_ready_i = 1'b0;
        wb = writes;
        start_job(8'h20, 8'd5);
        for (int i = 0; i < 4; i++) drive_word(pat(3, i), 1'b1, 8'(8'h20 + i));
        chk("j3_no_ovf_yet", WW'(overflow_o), WW'(1'b0));
        drive_word(pat(3, 4), 1'b0, 8'h00);
        chk("j3_overflow", WW'(overflow_o), WW'(1'b1));
        gbuff_ready_i = 1'b1;
        wait_done("j3_done", 20);
        tick();
        chk("j3_writes", WW'(writes - wb), WW'(4));
        chk("j3_sb_empty", WW'(exp_q.size()), WW'(0));
        chk("j3_ovf_sticky", WW'(overflow_o), WW'(1'b1));

        // Job 4: ready toggling every cycle, eight words.
        wb = writes;
        start_job(8'h40, 8'd8);
        chk("j4_ovf_cleared", WW'(overflow_o), WW'(1'b0));
        toggle_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_word(pat(4, i), 1'b1, 8'(8'h40 + i));
            tick();
        end
        wait_done("j4_done", 40);
        toggle_ready  = 1'b0;
        gbuff_ready_i = 1'b1;
        tick();
        chk("j4_writes", WW'(writes - wb), WW'(8));
        chk("j4_sb_empty", WW'(exp_q.size()), WW'(0));
        chk("j4_overflow", WW'(overflow_o), WW'(1'b0));

        // Job 5: zero-length job, then words offered while idle.
        pb = done_pulses;
        wb = writes;
        start_job(8'h50, 8'd0);
        wait_done("j5_done", 2);
        tick();
        chk("j5_done_pulses", WW'(done_pulses - pb), WW'(1));
        chk("j5_idle", WW'(busy_o), WW'(1'b0));
        drive_word(pat(5, 0), 1'b0, 8'h00);
        drive_word(pat(5, 1), 1'b0, 8'h00);
        chk("j5_idle_wr_en", WW'(gbuff_wr_en_o), WW'(1'b0));
        tick();
        chk("j5_writes", WW'(writes - wb), WW'(0));
        chk("j5_overflow", WW'(overflow_o), WW'(1'b0));

        // Job 6: reset with words queued, then a fresh job.
        gbuff_ready_i = 1'b0;
        wb = writes;
        start_job(8'h80, 8'd4);
        drive_word(pat(6, 0), 1'b0, 8'h00);
        drive_word(pat(6, 1), 1'b0, 8'h00);
        chk("j6_queued", WW'(gbuff_wr_en_o), WW'(1'b1));
        rst_ni = 1'b0;
        tick();
        chk("j6_rst_wr_en", WW'(gbuff_wr_en_o), WW'(1'b0));
        chk("j6_rst_addr", WW'(gbuff_addr_o), WW'(8'h00));
        chk("j6_rst_wdata", gbuff_wdata_o, '0);
        chk("j6_rst_busy", WW'(busy_o), WW'(1'b0));
        chk("j6_rst_done", WW'(done_o), WW'(1'b0));
        chk("j6_rst_overflow", WW'(overflow_o), WW'(1'b0));
        rst_ni        = 1'b1;
        gbuff_ready_i = 1'b1;
        tick();
        chk("j6_post_rst_wr_en", WW'(gbuff_wr_en_o), WW'(1'b0));
        start_job(8'h90, 8'd2);
        drive_word(pat(7, 0), 1'b1, 8'h90);
        drive_word(pat(7, 1), 1'b1, 8'h91);
        wait_done("j6_done", 20);
        tick();
        chk("j6_writes", WW'(writes - wb), WW'(2));
        chk("j6_sb_empty", WW'(exp_q.size()), WW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
